// File: rtl/seg7_scan_display_pkg.sv
// Shared constants for the clock display path: segment patterns, field
// encodings for the adjust selector, digit positions and per-digit limits.
package seg7_scan_display_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Field selected by the adjust logic
  typedef enum logic [1:0] {
    F_MIN  = 2'd0,
    F_HR   = 2'd1,
    F_AMIN = 2'd2,
    F_AHR  = 2'd3
  } field_t;

  // Digit positions, matching the an[] bit index
  localparam logic [1:0] POS_MIN_UNITS = 2'd0;
  localparam logic [1:0] POS_MIN_TENS  = 2'd1;
  localparam logic [1:0] POS_HR_UNITS  = 2'd2;
  localparam logic [1:0] POS_HR_TENS   = 2'd3;

  // Largest legal value per digit; anything above shows a dash
  localparam logic [3:0] MAX_UNITS    = 4'd9;
  localparam logic [3:0] MAX_MIN_TENS = 4'd5;
  localparam logic [3:0] MAX_HR_TENS  = 4'd2;

  function automatic logic [6:0] digit_pattern(input logic [3:0] value);
    logic [6:0] pat;
    case (value)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

  function automatic logic is_hours_field(input field_t f);
    return (f == F_HR) || (f == F_AHR);
  endfunction

  function automatic logic is_alarm_field(input field_t f);
    return (f == F_AMIN) || (f == F_AHR);
  endfunction

endpackage

// File: rtl/seg7_scan_display_if.sv
// Bundle between the adjust/counter logic and the display reader: the two
// BCD digit buses, the adjust controls, and the display pin outputs.
interface seg7_scan_display_if;
  logic [1:0] hourtens;
  logic [3:0] hourunits;
  logic [2:0] mintens;
  logic [3:0] minunits;
  logic [1:0] hourtens_alarm;
  logic [3:0] hourunits_alarm;
  logic [2:0] mintens_alarm;
  logic [3:0] minunits_alarm;
  logic       en;
  logic [1:0] sel;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (
    output hourtens, hourunits, mintens, minunits,
    output hourtens_alarm, hourunits_alarm, mintens_alarm, minunits_alarm,
    output en, sel,
    input  an, seg, dp
  );

  modport slave (
    input  hourtens, hourunits, mintens, minunits,
    input  hourtens_alarm, hourunits_alarm, mintens_alarm, minunits_alarm,
    input  en, sel,
    output an, seg, dp
  );
endinterface

// File: rtl/seg7_scan_display_bcd_to_7seg.sv
// Single-digit decoder: BCD value to active-low segments, with a per-digit
// upper limit (out-of-range shows a dash) and a forced-blank input.
module bcd_to_7seg
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] value,
  input  logic [3:0] max_digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins, then range check, then the digit table
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else if (value > max_digit) begin
      seg = SEG_DASH;
    end else begin
      seg = digit_pattern(value);
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Scanned 4-digit common-anode display reader. Snapshots the time or alarm
// digits once per scan frame so a frame never mixes old and new values,
// multiplexes one digit per refresh slot, and blinks the selected field.
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int REFRESH_DIV  = 25000,
  parameter int BLINK_FRAMES = 125,
  parameter bit BLANK_LZ     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  seg7_scan_display_if.slave bus
);

  localparam int RC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [RC_W-1:0] rc;
  logic [1:0]      si;
  logic [FC_W-1:0] fc;
  logic            bp;

  logic [1:0] snap_ht;
  logic [3:0] snap_hu;
  logic [2:0] snap_mt;
  logic [3:0] snap_mu;
  logic       snap_en;
  field_t     snap_sel;

  logic [3:0] an_q;
  logic [6:0] seg_q;
  logic       dp_q;

  logic       rc_wrap;
  logic       frame_start;
  logic       use_alarm;
  logic [3:0] digit_value;
  logic [3:0] digit_max;
  logic       digit_blank;
  logic [6:0] seg_next;
  logic [3:0] an_next;
  logic       dp_next;

  assign rc_wrap     = (rc == RC_LAST);
  assign frame_start = rc_wrap && (si == POS_HR_TENS);
  assign use_alarm   = bus.en && is_alarm_field(field_t'(bus.sel));

  // Refresh/scan/frame counters and the once-per-frame input snapshot
  always_ff @(posedge clk) begin
    if (rst) begin
      rc       <= '0;
      si       <= '0;
      fc       <= '0;
      bp       <= 1'b0;
      snap_ht  <= '0;
      snap_hu  <= '0;
      snap_mt  <= '0;
      snap_mu  <= '0;
      snap_en  <= 1'b0;
      snap_sel <= F_MIN;
    end else begin
      if (rc_wrap) begin
        rc <= '0;
        si <= si + 2'd1;
      end else begin
        rc <= rc + 1'b1;
      end
      if (frame_start) begin
        snap_ht  <= use_alarm ? bus.hourtens_alarm  : bus.hourtens;
        snap_hu  <= use_alarm ? bus.hourunits_alarm : bus.hourunits;
        snap_mt  <= use_alarm ? bus.mintens_alarm   : bus.mintens;
        snap_mu  <= use_alarm ? bus.minunits_alarm  : bus.minunits;
        snap_en  <= bus.en;
        snap_sel <= field_t'(bus.sel);
        if (fc == FC_LAST) begin
          fc <= '0;
          bp <= ~bp;
        end else begin
          fc <= fc + 1'b1;
        end
      end
    end
  end

  // Scan mux: pick the current digit, its limit, and whether it is dark
  always_comb begin
    digit_value = snap_mu;
    digit_max   = MAX_UNITS;
    case (si)
      POS_MIN_UNITS: begin digit_value = snap_mu;         digit_max = MAX_UNITS;    end
      POS_MIN_TENS:  begin digit_value = {1'b0, snap_mt}; digit_max = MAX_MIN_TENS; end
      POS_HR_UNITS:  begin digit_value = snap_hu;         digit_max = MAX_UNITS;    end
      default:       begin digit_value = {2'b00, snap_ht}; digit_max = MAX_HR_TENS; end
    endcase
    digit_blank = (snap_en && bp && (si[1] == is_hours_field(snap_sel)))
               || (BLANK_LZ && (si == POS_HR_TENS) && (snap_ht == 2'd0));
    an_next = digit_blank ? 4'b1111 : ~(4'b0001 << si);
    dp_next = 1'b1;
    if (si == POS_HR_UNITS) begin
      dp_next = snap_en ? 1'b0 : ~bp;
    end
  end

  bcd_to_7seg u_decode (
    .value     (digit_value),
    .max_digit (digit_max),
    .blank     (digit_blank),
    .seg       (seg_next)
  );

  // Registered display pins, one cycle behind the scan index
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_next;
      seg_q <= seg_next;
      dp_q  <= dp_next;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a cycle-count reference model
// predicts {an,seg,dp} on every edge, and the checker compares on negedge.
module tb_seg7_scan_display;

  localparam int RD = 4;
  localparam int BF = 2;
  localparam int FRAME = 4 * RD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  seg7_scan_display_if bus ();

  seg7_scan_display #(
    .REFRESH_DIV  (RD),
    .BLINK_FRAMES (BF),
    .BLANK_LZ     (1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  string phase = "reset";
  logic [11:0] sbq[$];

  // Reference model state: edges since reset plus the frame snapshot
  int mc = 0;
  logic [1:0] mht = '0;
  logic [3:0] mhu = '0;
  logic [2:0] mmt = '0;
  logic [3:0] mmu = '0;
  logic men = 1'b0;
  logic [1:0] msel = '0;

  task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
    checks++;
    if (observed === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s @%0t: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               tag, $time, observed[11:8], observed[7:1], observed[0],
               expected[11:8], expected[7:1], expected[0]);
    end
  endtask

  function automatic logic [6:0] expSeg(input int v, input int mx);
    if (v > mx) return 7'b0111111;
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [11:0] expOut(input int s, input bit b);
    int v, mx;
    bit hoursDigit, selHours, dark;
    logic [3:0] a;
    logic [6:0] sg;
    logic d;
    case (s)
      0: begin v = int'(mmu); mx = 9; end
      1: begin v = int'(mmt); mx = 5; end
      2: begin v = int'(mhu); mx = 9; end
      default: begin v = int'(mht); mx = 2; end
    endcase
    hoursDigit = (s >= 2);
    selHours = (msel == 2'd1) || (msel == 2'd3);
    dark = (men && b && (hoursDigit == selHours)) || (s == 3 && mht == 2'd0);
    a = dark ? 4'b1111 : ~(4'b0001 << s);
    sg = dark ? 7'b1111111 : expSeg(v, mx);
    d = (s == 2) ? (men ? 1'b0 : ~b) : 1'b1;
    return {a, sg, d};
  endfunction

  // Model: predict what each edge registers, load snapshot on frame start
  initial forever begin
    logic [11:0] e;
    int s, fr;
    bit b;
    @(posedge clk);
    if (rst) begin
      e = 12'hFFF;
      mc = 0;
      mht = '0; mhu = '0; mmt = '0; mmu = '0; men = 1'b0; msel = '0;
    end else begin
      s = (mc / RD) % 4;
      fr = mc / FRAME;
      b = ((fr / BF) % 2) == 1;
      e = expOut(s, b);
      if ((mc % FRAME) == FRAME - 1) begin
        if (bus.en && bus.sel[1]) begin
          mht = bus.hourtens_alarm; mhu = bus.hourunits_alarm;
          mmt = bus.mintens_alarm;  mmu = bus.minunits_alarm;
        end else begin
          mht = bus.hourtens; mhu = bus.hourunits;
          mmt = bus.mintens;  mmu = bus.minunits;
        end
        men = bus.en;
        msel = bus.sel;
      end
      mc++;
    end
    sbq.push_back(e);
  end

  // Checker: pop one prediction per edge and compare away from the edge
  initial forever begin
    @(negedge clk);
    if (sbq.size() > 0) begin
      checkOutput(phase, {bus.an, bus.seg, bus.dp}, sbq.pop_front());
    end
  end

  task automatic applyStimulus(input logic [1:0] ht, input logic [3:0] hu,
                               input logic [2:0] mt, input logic [3:0] mu,
                               input logic e, input logic [1:0] s, input int cycles);
    bus.hourtens = ht;
    bus.hourunits = hu;
    bus.mintens = mt;
    bus.minunits = mu;
    bus.en = e;
    bus.sel = s;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    bus.hourtens = '0; bus.hourunits = '0; bus.mintens = '0; bus.minunits = '0;
    bus.hourtens_alarm = 2'd0; bus.hourunits_alarm = 4'd7;
    bus.mintens_alarm = 3'd3; bus.minunits_alarm = 4'd0;
    bus.en = 1'b0; bus.sel = 2'd0;

    repeat (3) @(negedge clk);
    checkOutput("reset_state", {bus.an, bus.seg, bus.dp}, 12'hFFF);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("first_digit0", {bus.an, bus.seg, bus.dp}, 12'hE81);

    phase = "time_12_34";
    applyStimulus(2'd1, 4'd2, 3'd3, 4'd4, 1'b0, 2'd0, 5 * FRAME);

    phase = "time_09_59";
    applyStimulus(2'd0, 4'd9, 3'd5, 4'd9, 1'b0, 2'd0, 4 * FRAME);

    phase = "alarm_hr_blink";
    applyStimulus(2'd1, 4'd2, 3'd3, 4'd4, 1'b1, 2'd3, 6 * FRAME);

    phase = "time_min_blink";
    applyStimulus(2'd1, 4'd2, 3'd3, 4'd4, 1'b1, 2'd0, 5 * FRAME);

    phase = "midframe_change";
    applyStimulus(2'd1, 4'd2, 3'd3, 4'd4, 1'b0, 2'd0, 2 * FRAME + 5);
    applyStimulus(2'd1, 4'd2, 3'd3, 4'd5, 1'b0, 2'd0, 3 * FRAME);

    phase = "dash";
    applyStimulus(2'd1, 4'd2, 3'd7, 4'hC, 1'b0, 2'd0, 3 * FRAME);

    phase = "random";
    for (int i = 0; i < 12; i++) begin
      applyStimulus(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                    3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    int'($urandom_range(3, 11)));
      bus.hourtens_alarm = 2'($urandom_range(0, 3));
      bus.minunits_alarm = 4'($urandom_range(0, 15));
    end

    phase = "pre_reset";
    applyStimulus(2'd1, 4'd2, 3'd3, 4'd4, 1'b0, 2'd0, 2 * FRAME + 7);
    phase = "midframe_reset";
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_wins", {bus.an, bus.seg, bus.dp}, 12'hFFF);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("restart_digit0", {bus.an, bus.seg, bus.dp}, 12'hE81);
    phase = "after_reset";
    applyStimulus(2'd1, 4'd2, 3'd3, 4'd4, 1'b0, 2'd0, 3 * FRAME);

    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
